// File: rtl/gear_shift_controller.sv
// gear_shift_controller: closes the loop between the engine/speed model and
// its gear input. Auto mode shifts on rpm thresholds with a post-shift hold-off;
// manual mode takes up/down button pulses and refuses illegal requests.
// Every shift passes through a timed clutch-disengaged phase (gear=0).
// Optional build macro: GEAR_SHIFT_KICKDOWN_EN (throttle-stab kickdown in auto).
module gear_shift_controller #(
    parameter int UP_RPM      = 2500,
    parameter int DOWN_RPM    = 1200,
    parameter int SHIFT_TICKS = 3,
    parameter int HOLD_TICKS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_10hz,
    input  logic [8:0] speed_kmh,
    input  logic [13:0] rpm,
    input  logic       throttle,
    input  logic       brake,
    input  logic       mode_auto,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] gear,
    output logic       shifting,
    output logic       shift_reject
);

    typedef enum logic [1:0] {
        ST_NEUTRAL  = 2'd0,
        ST_DRIVE    = 2'd1,
        ST_SHIFTING = 2'd2
    } state_t;

    localparam logic [13:0] UP_TH      = 14'(UP_RPM);
    localparam logic [13:0] DOWN_TH    = 14'(DOWN_RPM);
    localparam logic [7:0]  SHIFT_VAL  = 8'(SHIFT_TICKS);
    localparam logic [7:0]  HOLD_VAL   = 8'(HOLD_TICKS);

    state_t      state_q, state_d;
    logic [2:0]  gear_q, gear_d;
    logic        shifting_q, shifting_d;
    logic        reject_q, reject_d;
    logic [2:0]  target_q, target_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        pend_up_q, pend_up_d;
    logic        pend_down_q, pend_down_d;

    // Requests seen at a tick include a pulse landing on the tick cycle itself.
    logic        req_up, req_down;
    logic        start_shift;
    logic [2:0]  new_gear;
    logic        go_drive;

    assign req_up   = pend_up_q | btn_up;
    assign req_down = pend_down_q | btn_down;

`ifdef GEAR_SHIFT_KICKDOWN_EN
    localparam logic [13:0] KICK_TH = 14'(UP_RPM / 2);
    logic thr_prev_q, thr_prev_d;
    logic kick;
`endif

    // Highest speed at which a given gear may be engaged by a manual downshift.
    function automatic logic [8:0] max_speed(input logic [2:0] g);
        case (g)
            3'd1:    max_speed = 9'd30;
            3'd2:    max_speed = 9'd70;
            3'd3:    max_speed = 9'd130;
            3'd4:    max_speed = 9'd200;
            3'd5:    max_speed = 9'd300;
            default: max_speed = 9'd0;
        endcase
    endfunction

    // State register; async reset clears everything including mid-shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_NEUTRAL;
            gear_q      <= 3'd0;
            shifting_q  <= 1'b0;
            reject_q    <= 1'b0;
            target_q    <= 3'd0;
            cnt_q       <= 8'd0;
            hold_q      <= 8'd0;
            pend_up_q   <= 1'b0;
            pend_down_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gear_q      <= gear_d;
            shifting_q  <= shifting_d;
            reject_q    <= reject_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            pend_up_q   <= pend_up_d;
            pend_down_q <= pend_down_d;
        end
    end

`ifdef GEAR_SHIFT_KICKDOWN_EN
    // Throttle sampled once per tick for kickdown edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_prev_q <= 1'b0;
        end else begin
            thr_prev_q <= thr_prev_d;
        end
    end
`endif

    // Next-state and output decisions; nothing but button capture moves off-tick.
    always_comb begin
        state_d     = state_q;
        gear_d      = gear_q;
        shifting_d  = shifting_q;
        reject_d    = 1'b0;
        target_d    = target_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        pend_up_d   = req_up;
        pend_down_d = req_down;
        start_shift = 1'b0;
        new_gear    = gear_q;
        go_drive    = 1'b0;
`ifdef GEAR_SHIFT_KICKDOWN_EN
        thr_prev_d  = tick_10hz ? throttle : thr_prev_q;
        kick        = throttle && !thr_prev_q && mode_auto &&
                      (gear_q >= 3'd3) && (rpm < KICK_TH);
`endif
        if (tick_10hz) begin
            pend_up_d   = 1'b0;
            pend_down_d = 1'b0;
            case (state_q)
                ST_NEUTRAL: begin
                    go_drive = (throttle && !brake) || (req_up && !req_down);
                    if (req_up && req_down) begin
                        reject_d = 1'b1;
                    end else if (req_down && !go_drive) begin
                        reject_d = 1'b1;
                    end
                    if (go_drive) begin
                        gear_d  = 3'd1;
                        state_d = ST_DRIVE;
                        hold_d  = HOLD_VAL;
                    end
                end
                ST_DRIVE: begin
                    if (brake && (speed_kmh == 9'd0) && (gear_q == 3'd1)) begin
                        gear_d  = 3'd0;
                        state_d = ST_NEUTRAL;
                    end else if (!mode_auto && (req_up || req_down)) begin
                        if (req_up && req_down) begin
                            reject_d = 1'b1;
                        end else if (req_up) begin
                            if (gear_q < 3'd6) begin
                                start_shift = 1'b1;
                                new_gear    = gear_q + 3'd1;
                            end else begin
                                reject_d = 1'b1;
                            end
                        end else if ((gear_q > 3'd1) &&
                                     (speed_kmh <= max_speed(gear_q - 3'd1))) begin
                            start_shift = 1'b1;
                            new_gear    = gear_q - 3'd1;
                        end else begin
                            reject_d = 1'b1;
                        end
`ifdef GEAR_SHIFT_KICKDOWN_EN
                    end else if (kick) begin
                        start_shift = 1'b1;
                        new_gear    = gear_q - 3'd1;
`endif
                    end else if (mode_auto && (hold_q == 8'd0) && (rpm >= UP_TH) &&
                                 throttle && !brake && (gear_q < 3'd6)) begin
                        start_shift = 1'b1;
                        new_gear    = gear_q + 3'd1;
                    end else if (mode_auto && (hold_q == 8'd0) && (rpm <= DOWN_TH) &&
                                 (gear_q > 3'd1)) begin
                        start_shift = 1'b1;
                        new_gear    = gear_q - 3'd1;
                    end else if (hold_q != 8'd0) begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                ST_SHIFTING: begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d      = 8'd0;
                        gear_d     = target_q;
                        shifting_d = 1'b0;
                        hold_d     = HOLD_VAL;
                        state_d    = ST_DRIVE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_NEUTRAL;
                end
            endcase
            if (start_shift) begin
                target_d   = new_gear;
                gear_d     = 3'd0;
                shifting_d = 1'b1;
                cnt_d      = SHIFT_VAL;
                state_d    = ST_SHIFTING;
            end
        end
    end

    assign gear         = gear_q;
    assign shifting     = shifting_q;
    assign shift_reject = reject_q;

endmodule

// File: tb/tb_gear_shift_controller.sv
// Directed bench for gear_shift_controller with default parameters
// (UP_RPM=2500, DOWN_RPM=1200, SHIFT_TICKS=3, HOLD_TICKS=5).
module tb_gear_shift_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_10hz = 1'b0;
    logic [8:0] speed_kmh = 9'd0;
    logic [13:0] rpm = 14'd0;
    logic       throttle = 1'b0;
    logic       brake = 1'b0;
    logic       mode_auto = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [2:0] gear;
    logic       shifting;
    logic       shift_reject;

    int tests = 0;
    int fails = 0;
    int ticks = 0;

    gear_shift_controller dut (
        .clk          (clk),
        .rst          (rst),
        .tick_10hz    (tick_10hz),
        .speed_kmh    (speed_kmh),
        .rpm          (rpm),
        .throttle     (throttle),
        .brake        (brake),
        .mode_auto    (mode_auto),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .gear         (gear),
        .shifting     (shifting),
        .shift_reject (shift_reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int g, input int s, input int r);
        chk({tag, ".gear"}, int'(gear), g);
        chk({tag, ".shifting"}, int'(shifting), s);
        chk({tag, ".reject"}, int'(shift_reject), r);
    endtask

    // One tick strobe; returns at the falling edge right after the deciding edge.
    task automatic do_tick();
        @(negedge clk) tick_10hz = 1'b1;
        @(negedge clk) tick_10hz = 1'b0;
        ticks++;
        $display("[TB] tick %0d: rpm=%0d spd=%0d thr=%0d brk=%0d auto=%0d -> gear=%0d shifting=%0d reject=%0d",
                 ticks, rpm, speed_kmh, throttle, brake, mode_auto, gear, shifting, shift_reject);
    endtask

    task automatic press_up();
        @(negedge clk) btn_up = 1'b1;
        @(negedge clk) btn_up = 1'b0;
    endtask

    task automatic press_down();
        @(negedge clk) btn_down = 1'b1;
        @(negedge clk) btn_down = 1'b0;
    endtask

    // Three ticks of clutch phase: disengaged for two, engaged on the third.
    task automatic finish_shift(input string tag, input int g);
        do_tick(); chk_out({tag, ".c1"}, 0, 1, 0);
        do_tick(); chk_out({tag, ".c2"}, 0, 1, 0);
        do_tick(); chk_out({tag, ".done"}, g, 0, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_out("reset", 0, 0, 0);
        rst = 1'b0;

        // Test 1: get into a shift, then reset mid-shift
        mode_auto = 1'b1; throttle = 1'b1; rpm = 14'd1500;
        do_tick(); chk_out("t1.leave_neutral", 1, 0, 0);
        for (int i = 0; i < 5; i++) do_tick();
        chk_out("t1.hold_burn", 1, 0, 0);
        rpm = 14'd2600;
        do_tick(); chk_out("t1.shift_start", 0, 1, 0);
        #2 rst = 1'b1;
        #1 chk_out("t1.async_reset", 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        do_tick(); chk_out("t1.reengage", 1, 0, 0);

        // Test 2: auto upshift 1->2, then hold-off suppresses 5 ticks
        rpm = 14'd1500;
        for (int i = 0; i < 5; i++) do_tick();
        chk_out("t2.hold_burn", 1, 0, 0);
        rpm = 14'd2600;
        do_tick(); chk_out("t2.up_start", 0, 1, 0);
        finish_shift("t2.up12", 2);
        for (int i = 0; i < 5; i++) begin
            do_tick(); chk_out("t2.hold", 2, 0, 0);
        end
        do_tick(); chk_out("t2.hold_expired", 0, 1, 0);
        finish_shift("t2.up23", 3);

        // Climb to gear 4 for the downshift case
        for (int i = 0; i < 5; i++) do_tick();
        do_tick(); chk_out("t3.up34_start", 0, 1, 0);
        brake = 1'b1; mode_auto = 1'b0;  // must not abort the shift
        finish_shift("t3.up34", 4);
        brake = 1'b0; mode_auto = 1'b1;

        // Test 3: auto downshift 4->3 on low rpm
        rpm = 14'd1100; throttle = 1'b0;
        for (int i = 0; i < 5; i++) do_tick();
        chk_out("t3.hold_burn", 4, 0, 0);
        do_tick(); chk_out("t3.down_start", 0, 1, 0);
        finish_shift("t3.down43", 3);

        // Test 4: manual downshift with speed limit (gear 2 max 70)
        mode_auto = 1'b0; rpm = 14'd1500; speed_kmh = 9'd90;
        press_down();
        do_tick(); chk_out("t4.too_fast", 3, 0, 1);
        @(negedge clk) chk_out("t4.reject_one_cycle", 3, 0, 0);
        speed_kmh = 9'd70;
        press_down();
        do_tick(); chk_out("t4.down_start", 0, 1, 0);
        finish_shift("t4.down32", 2);

        // Test 5: manual upshifts to 6, then illegal requests
        for (int g = 3; g <= 6; g++) begin
            press_up();
            do_tick(); chk_out("t5.up_start", 0, 1, 0);
            finish_shift("t5.up", g);
        end
        press_up();
        do_tick(); chk_out("t5.up_at_6", 6, 0, 1);
        press_up();
        press_down();
        do_tick(); chk_out("t5.both", 6, 0, 1);
        @(negedge clk) chk_out("t5.both_single", 6, 0, 0);
        do_tick(); chk_out("t5.flags_cleared", 6, 0, 0);

        // Test 6: manual down to 1 at standstill, brake to neutral
        speed_kmh = 9'd0;
        for (int g = 5; g >= 1; g--) begin
            press_down();
            do_tick();
            finish_shift("t6.down", g);
        end
        brake = 1'b1;
        do_tick(); chk_out("t6.neutral", 0, 0, 0);
        press_down();
        do_tick(); chk_out("t6.down_in_neutral", 0, 0, 1);
        press_up();
        do_tick(); chk_out("t6.up_from_neutral", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
